usb_slave_bus_master: RTL and testbench

USB_SLAVE_BUS_MASTER -- requirements
Module: usb_slave_bus_master

---
 rtl/usb_slave_bus_master_if.sv | 32 +++
 rtl/usb_slave_bus_master.sv | 95 +++++++++
 tb/tb_usb_slave_bus_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/usb_slave_bus_master_if.sv
// Signal bundle between the command/response side, the bus master and the USB slave register port.
// The master modport is the bus master's view; the slave modport is the view of whatever drives it.
interface usb_slave_bus_master_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [7:0] req_addr_i;
  logic [7:0] req_data_i;
  logic       req_we_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_data_o;
  logic       rsp_err_o;
  logic [7:0] address_o;
  logic [7:0] data_o;
  logic       we_o;
  logic       strobe_o;
  logic       ack_i;
  logic [7:0] data_i;
  logic       busy_o;

  modport master (
    input  req_valid_i, req_addr_i, req_data_i, req_we_i, rsp_ready_i, ack_i, data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, address_o, data_o, we_o,
           strobe_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_data_i, req_we_i, rsp_ready_i, ack_i, data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, address_o, data_o, we_o,
           strobe_o, busy_o
  );
endinterface

// File: rtl/usb_slave_bus_master.sv
// Single-outstanding command bridge onto a strobe/ack slave register port; all outputs registered.
// Optional bus timeout enabled by defining USB_SLAVE_BUS_MASTER_TIMEOUT_EN.
module usb_slave_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk_i,
  input logic rst_i,
  usb_slave_bus_master_if.master bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

`ifdef USB_SLAVE_BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;
`else
  assign bus.rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      bus.req_ready_o <= 1'b1;
      bus.strobe_o    <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_data_o  <= 8'h00;
      bus.address_o   <= 8'h00;
      bus.data_o      <= 8'h00;
      bus.we_o        <= 1'b0;
      bus.busy_o      <= 1'b0;
`ifdef USB_SLAVE_BUS_MASTER_TIMEOUT_EN
      bus.rsp_err_o   <= 1'b0;
      cnt             <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.address_o   <= bus.req_addr_i;
            bus.data_o      <= bus.req_data_i;
            bus.we_o        <= bus.req_we_i;
            bus.strobe_o    <= 1'b1;
            bus.req_ready_o <= 1'b0;
            bus.busy_o      <= 1'b1;
            state           <= BUS;
`ifdef USB_SLAVE_BUS_MASTER_TIMEOUT_EN
            cnt             <= 8'd0;
`endif
          end
        end
        BUS: begin
          // ack is checked first so an ack on the limit cycle still completes normally
          if (bus.ack_i) begin
            bus.strobe_o    <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_data_o  <= bus.we_o ? 8'h00 : bus.data_i;
            state           <= RESP;
`ifdef USB_SLAVE_BUS_MASTER_TIMEOUT_EN
            bus.rsp_err_o   <= 1'b0;
          end else if (cnt == LIMIT) begin
            bus.strobe_o    <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_data_o  <= 8'hFF;
            bus.rsp_err_o   <= 1'b1;
            state           <= RESP;
          end else begin
            cnt             <= cnt + 8'd1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.req_ready_o <= 1'b1;
            bus.busy_o      <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          state           <= IDLE;
          bus.strobe_o    <= 1'b0;
          bus.rsp_valid_o <= 1'b0;
          bus.req_ready_o <= 1'b1;
          bus.busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_slave_bus_master.sv
// Self-checking bench: vector table of transactions with a response scoreboard, plus reset/spurious-ack sequences.
module tb_usb_slave_bus_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  usb_slave_bus_master_if bus ();

  usb_slave_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ack_after;   // strobe cycle on which ack is given; 0 = never
    logic [7:0] rdata;
    int         hold;        // cycles rsp_ready stays low (with req_valid high)
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_strobes;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response handshake is compared against the oldest expectation.
  always @(posedge clk) begin
    if (rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: got data %0h with no pending transaction", bus.rsp_data_o);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", {24'h0, bus.rsp_data_o}, {24'h0, e.data});
        chk("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, e.err});
      end
    end
  end

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 8'h00;
    bus.req_data_i  = 8'h00;
    bus.req_we_i    = 1'b0;
    bus.rsp_ready_i = 1'b0;
    bus.ack_i       = 1'b0;
    bus.data_i      = 8'h00;
  endtask

  task automatic run_txn(input vec_t v);
    int strobes;
    rsp_t e;
    chk("req_ready_idle", {31'h0, bus.req_ready_o}, 32'h1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_data_i  = v.wdata;
    bus.req_we_i    = v.we;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = ~v.addr;
    bus.req_data_i  = ~v.wdata;
    e.data = v.exp_data;
    e.err  = v.exp_err;
    sb.push_back(e);
    chk("strobe_after_accept", {31'h0, bus.strobe_o}, 32'h1);
    strobes = 0;
    while (bus.strobe_o === 1'b1 && strobes < 300) begin
      strobes++;
      chk("address_stable", {24'h0, bus.address_o}, {24'h0, v.addr});
      chk("data_stable", {24'h0, bus.data_o}, {24'h0, v.wdata});
      chk("we_stable", {31'h0, bus.we_o}, {31'h0, v.we});
      chk("busy_in_bus", {31'h0, bus.busy_o}, 32'h1);
      chk("req_ready_in_bus", {31'h0, bus.req_ready_o}, 32'h0);
      if (strobes == v.ack_after) begin
        bus.ack_i  = 1'b1;
        bus.data_i = v.rdata;
      end
      @(negedge clk);
      bus.ack_i  = 1'b0;
      bus.data_i = 8'h5C;
    end
    chk("strobe_cycles", strobes, v.exp_strobes);
    chk("rsp_valid_after_bus", {31'h0, bus.rsp_valid_o}, 32'h1);
    for (int i = 0; i < v.hold; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 8'h99;
      @(negedge clk);
      chk("rsp_valid_hold", {31'h0, bus.rsp_valid_o}, 32'h1);
      chk("rsp_data_hold", {24'h0, bus.rsp_data_o}, {24'h0, v.exp_data});
      chk("req_ready_hold", {31'h0, bus.req_ready_o}, 32'h0);
      chk("no_strobe_hold", {31'h0, bus.strobe_o}, 32'h0);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("rsp_valid_cleared", {31'h0, bus.rsp_valid_o}, 32'h0);
    chk("busy_cleared", {31'h0, bus.busy_o}, 32'h0);
    chk("address_retained", {24'h0, bus.address_o}, {24'h0, v.addr});
  endtask

  initial begin
    //       we    addr   wdata  ack rdata  hold  exp    err strobes
    vecs.push_back('{1'b1, 8'h04, 8'h5A, 2, 8'h77, 0, 8'h00, 1'b0, 2});
    vecs.push_back('{1'b0, 8'h20, 8'h00, 1, 8'hC3, 0, 8'hC3, 1'b0, 1});
    vecs.push_back('{1'b0, 8'h7F, 8'h12, 3, 8'h3C, 5, 8'h3C, 1'b0, 3});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 1, 8'hAA, 0, 8'h00, 1'b0, 1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 4, 8'hA5, 2, 8'hA5, 1'b0, 4});
    vecs.push_back('{1'b0, 8'h11, 8'h00, 1, 8'hFF, 0, 8'hFF, 1'b0, 1});
`ifdef USB_SLAVE_BUS_MASTER_TIMEOUT_EN
    vecs.push_back('{1'b0, 8'h33, 8'h00, 0, 8'h00, 1, 8'hFF, 1'b1, TO});
    vecs.push_back('{1'b0, 8'h34, 8'h00, TO, 8'h42, 0, 8'h42, 1'b0, TO});
    vecs.push_back('{1'b1, 8'h35, 8'h66, 0, 8'h00, 0, 8'hFF, 1'b1, TO});
`else
    vecs.push_back('{1'b0, 8'h33, 8'h00, 20, 8'h42, 0, 8'h42, 1'b0, 20});
`endif

    idle_inputs();
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 8'hEE;
    bus.ack_i       = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_strobe", {31'h0, bus.strobe_o}, 32'h0);
    chk("reset_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
    chk("reset_rsp_data", {24'h0, bus.rsp_data_o}, 32'h0);
    chk("reset_rsp_err", {31'h0, bus.rsp_err_o}, 32'h0);
    chk("reset_address", {24'h0, bus.address_o}, 32'h0);
    chk("reset_data", {24'h0, bus.data_o}, 32'h0);
    chk("reset_we", {31'h0, bus.we_o}, 32'h0);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", {31'h0, bus.req_ready_o}, 32'h1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in BUS aborts with no response.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 8'h55;
    bus.req_we_i    = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("strobe_before_abort", {31'h0, bus.strobe_o}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_strobe", {31'h0, bus.strobe_o}, 32'h0);
    chk("abort_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("abort_address", {24'h0, bus.address_o}, 32'h0);
    // Spurious ack in IDLE produces nothing.
    bus.ack_i       = 1'b1;
    bus.data_i      = 8'hBD;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("spurious_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
      chk("spurious_busy", {31'h0, bus.busy_o}, 32'h0);
      chk("spurious_strobe", {31'h0, bus.strobe_o}, 32'h0);
    end
    idle_inputs();
    @(negedge clk);

    // One more transaction after the abort to confirm recovery.
    run_txn('{1'b1, 8'h42, 8'h24, 1, 8'h00, 0, 8'h00, 1'b0, 1});

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
